wb_ram_slave: RTL and testbench

- Wishbone classic-cycle responder: the slave end of the bus driven by the CPU's instruction and data Wishbone master interfaces.
- Fronts an on-chip word-organised RAM.
- Supports byte-lane writes, a programmable number of wait states and an error response for addresses outside its window.
- Attaches behind the bus interconnect as one slave port; one instance per memory region.

---
 rtl/wb_ram_slave.sv | 128 ++++++++++++
 tb/tb_wb_ram_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle RAM slave.
// Byte-lane writes, fixed wait states, error outside its window.
module wb_ram_slave #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic commit;
  logic req;
  logic in_range;
  logic wr_en;
  logic [ADDR_W-1:0] idx;
  logic unused_addr_bits;

  logic [31:0] ram [DEPTH];

  assign req = wb_cyc_i & wb_stb_i;
  assign in_range =
    wb_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign idx = wb_addr_i[ADDR_W+1:2];
  assign unused_addr_bits = ^wb_addr_i[1:0];

  // A write held across reset with zero wait states must not land.
  assign wr_en = commit & in_range & wb_we_i & ~rst;

  // Next-state: count wait states, abort on dropped request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_LD == 4'd0) begin
            state_n = S_RESP;
            commit  = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_n = S_RESP;
          cnt_n   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // State, counter and one-cycle response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wb_ack_o <= commit & in_range;
      wb_err_o <= commit & ~in_range;
    end
  end

  // Registered read port; holds last read word between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_o <= 32'h0;
    end else if (commit & ~in_range) begin
      wb_data_o <= 32'h0;
    end else if (commit & ~wb_we_i) begin
      wb_data_o <= ram[idx];
    end
  end

  // Byte-lane write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) begin
          ram[idx][8*i +: 8] <= wb_data_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave.
// Vector table plus scoreboard, and hand sequences for corners.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr, wb_wdat, wb_rdat;
  logic        wb_ack, wb_err;

  logic        b_cyc, b_stb, b_we;
  logic [3:0]  b_sel;
  logic [31:0] b_addr, b_wdat, b_rdat;
  logic        b_ack, b_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl [18];

  always #5 clk = ~clk;

  wb_ram_slave #(
    .ADDR_W(10),
    .BASE_ADDR(32'h0000_0000),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_cyc_i(wb_cyc),
    .wb_stb_i(wb_stb),
    .wb_we_i(wb_we),
    .wb_sel_i(wb_sel),
    .wb_addr_i(wb_addr),
    .wb_data_i(wb_wdat),
    .wb_data_o(wb_rdat),
    .wb_ack_o(wb_ack),
    .wb_err_o(wb_err)
  );

  wb_ram_slave #(
    .ADDR_W(10),
    .BASE_ADDR(32'h0000_0000),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .wb_cyc_i(b_cyc),
    .wb_stb_i(b_stb),
    .wb_we_i(b_we),
    .wb_sel_i(b_sel),
    .wb_addr_i(b_addr),
    .wb_data_i(b_wdat),
    .wb_data_o(b_rdat),
    .wb_ack_o(b_ack),
    .wb_err_o(b_err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack/err pulse pops one expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb_ack === 1'b1 || wb_err === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ack=%b err=%b expected none",
                 wb_ack, wb_err);
      end else begin
        e = sbq.pop_front();
        check($sformatf("ack[%0d]", e.tag), {31'b0, wb_ack},
              {31'b0, ~e.err});
        check($sformatf("err[%0d]", e.tag), {31'b0, wb_err},
              {31'b0, e.err});
        check($sformatf("data[%0d]", e.tag), wb_rdat, e.data);
      end
    end
  end

  task automatic do_xfer(input vec_t v, input int tag);
    int  n;
    bit  got;
    exp_t e;
    @(negedge clk);
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = v.we;
    wb_sel  = v.sel;
    wb_addr = v.addr;
    wb_wdat = v.wdata;
    e.err  = v.exp_err;
    e.data = v.exp_data;
    e.tag  = tag;
    sbq.push_back(e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (wb_ack || wb_err) got = 1'b1;
    end
    check($sformatf("latency[%0d]", tag), 32'(n), 32'd3);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    if (!got && sbq.size() != 0) void'(sbq.pop_back());
    @(posedge clk);
  endtask

  task automatic b2b(input logic we, input int k0);
    int  n;
    bit  got;
    @(negedge clk);
    b_cyc  = 1'b1;
    b_stb  = 1'b1;
    b_we   = we;
    b_sel  = 4'hF;
    b_addr = 32'h0;
    b_wdat = 32'hA000_0000;
    for (int k = 0; k < 3; k++) begin
      n   = 0;
      got = 1'b0;
      while (!got && n < 10) begin
        @(posedge clk);
        #1;
        n++;
        if (b_ack) got = 1'b1;
      end
      check($sformatf("b2b_gap[%0d]", k0 + k), 32'(n),
            (k == 0) ? 32'd1 : 32'd2);
      check($sformatf("b2b_err[%0d]", k0 + k), {31'b0, b_err}, 32'd0);
      if (!we) begin
        check($sformatf("b2b_data[%0d]", k0 + k), b_rdat,
              32'hA000_0000 + 32'(k));
      end
      b_addr = 32'(4 * (k + 1));
      b_wdat = 32'hA000_0000 + 32'(k + 1);
    end
    b_cyc = 1'b0;
    b_stb = 1'b0;
    @(posedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    vec_t v;

    tbl[0]  = '{1'b1, 4'hF, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 4'hF, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'h020, 32'h11223344, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 4'h5, 32'h020, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 4'h1, 32'h020, 32'h0, 1'b0, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 4'h0, 32'h020, 32'hFFFFFFFF, 1'b0, 32'h11BB33DD};
    tbl[6]  = '{1'b0, 4'hF, 32'h022, 32'h0, 1'b0, 32'h11BB33DD};
    tbl[7]  = '{1'b1, 4'hF, 32'h004, 32'h00000004, 1'b0, 32'h11BB33DD};
    tbl[8]  = '{1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 4'hF, 32'h1004, 32'hCAFEF00D, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 4'hF, 32'h004, 32'h0, 1'b0, 32'h00000004};
    tbl[11] = '{1'b1, 4'hF, 32'hFFC, 32'h0BADCAFE, 1'b0, 32'h00000004};
    tbl[12] = '{1'b0, 4'hF, 32'hFFC, 32'h0, 1'b0, 32'h0BADCAFE};
    tbl[13] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 4'hF, 32'h030, 32'h55AA55AA, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 4'hA, 32'h004, 32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 4'hF, 32'h004, 32'h0, 1'b0, 32'hFF00FF04};
    tbl[17] = '{1'b0, 4'hF, 32'h030, 32'h0, 1'b0, 32'h55AA55AA};

    rst = 1'b1;
    {wb_cyc, wb_stb, wb_we} = 3'b000;
    wb_sel = 4'h0; wb_addr = 32'h0; wb_wdat = 32'h0;
    {b_cyc, b_stb, b_we} = 3'b000;
    b_sel = 4'h0; b_addr = 32'h0; b_wdat = 32'h0;

    #12;
    check("rst_ack", {31'b0, wb_ack}, 32'd0);
    check("rst_err", {31'b0, wb_err}, 32'd0);
    check("rst_data", wb_rdat, 32'd0);
    check("rst_b_ack", {31'b0, b_ack}, 32'd0);
    check("rst_b_data", b_rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_xfer(tbl[i], i);
    end

    // Abort: drop stb after one WAIT cycle of a write to 0x30.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_sel = 4'hF; wb_addr = 32'h030; wb_wdat = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    wb_stb = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (wb_ack || wb_err) n++;
    end
    check("abort_no_resp", 32'(n), 32'd0);
    wb_cyc = 1'b0;
    v = '{1'b0, 4'hF, 32'h030, 32'h0, 1'b0, 32'h55AA55AA};
    do_xfer(v, 100);

    // Reset in WAIT of a write to 0x10.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_sel = 4'hF; wb_addr = 32'h010; wb_wdat = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'b0, wb_ack}, 32'd0);
    check("midrst_err", {31'b0, wb_err}, 32'd0);
    check("midrst_data", wb_rdat, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_ack_hold", {31'b0, wb_ack}, 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v = '{1'b0, 4'hF, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF};
    do_xfer(v, 101);

    // Zero-wait-state instance: back-to-back writes then reads.
    b2b(1'b1, 0);
    b2b(1'b0, 3);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
